core_mem_arbiter: RTL and testbench

- Shares the core's single memory port between instruction fetch (IF) and load/store (LS).
- Grants one requester at a time, registers the request payload and drives it downstream with a valid/ready handshake.
- Holds one outstanding transaction and routes its response back to the owner.
- Supports an IF flush that silently drops an in-flight fetch response, e.g. on branch redirect.

---
 rtl/core_pkg.sv | 27 ++
 rtl/core_mem_arbiter.sv | 193 +++++++++++++++++++
 tb/tb_core_mem_arbiter.sv | 328 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/core_pkg.sv
// Shared core types: machine word and the memory-arbiter owner/state/request types.
package core_pkg;

   localparam int unsigned WORD_W = 32;
   localparam int unsigned STRB_W = WORD_W / 8;

   typedef logic [WORD_W-1:0] word_t;

   typedef enum logic {
      MEM_OWNER_IF,
      MEM_OWNER_LS
   } mem_owner_e;

   typedef enum logic [1:0] {
      MEM_ARB_IDLE,
      MEM_ARB_REQ,
      MEM_ARB_WAIT_RSP
   } mem_arb_state_e;

   typedef struct packed {
      word_t              addr;
      logic               wen;
      word_t              wdata;
      logic [STRB_W-1:0]  wstrb;
   } mem_req_s;

endpackage

// File: rtl/core_mem_arbiter.sv
// Arbitrates the single memory port between instruction fetch and load/store,
// holding one outstanding transaction and steering its response to the owner.
module core_mem_arbiter
   import core_pkg::*;
#(
   parameter bit LS_PRIORITY = 1'b0
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_if_req_valid,
   output logic               o_if_req_ready,
   input  word_t              i_if_addr,
   input  logic               i_if_flush,
   output logic               o_if_rsp_valid,
   output word_t              o_if_rsp_data,
   output logic               o_if_rsp_err,
   input  logic               i_ls_req_valid,
   output logic               o_ls_req_ready,
   input  word_t              i_ls_addr,
   input  logic               i_ls_wen,
   input  word_t              i_ls_wdata,
   input  logic [STRB_W-1:0]  i_ls_wstrb,
   output logic               o_ls_rsp_valid,
   output word_t              o_ls_rsp_rdata,
   output logic               o_ls_rsp_err,
   output logic               o_mem_req_valid,
   input  logic               i_mem_req_ready,
   output word_t              o_mem_addr,
   output logic               o_mem_wen,
   output word_t              o_mem_wdata,
   output logic [STRB_W-1:0]  o_mem_wstrb,
   input  logic               i_mem_rsp_valid,
   input  word_t              i_mem_rsp_rdata,
   input  logic               i_mem_rsp_err
);

   mem_arb_state_e state_q, state_d;
   mem_owner_e     owner_q, owner_d;
   mem_owner_e     last_grant_q, last_grant_d;
   logic           drop_q, drop_d;
   mem_req_s       req_q, req_d;
   logic           mem_req_valid_q, mem_req_valid_d;
   logic           if_rsp_valid_q, if_rsp_valid_d;
   word_t          if_rsp_data_q, if_rsp_data_d;
   logic           if_rsp_err_q, if_rsp_err_d;
   logic           ls_rsp_valid_q, ls_rsp_valid_d;
   word_t          ls_rsp_rdata_q, ls_rsp_rdata_d;
   logic           ls_rsp_err_q, ls_rsp_err_d;

   logic           if_eligible_c;
   logic           grant_valid_c;
   mem_owner_e     grant_c;
   logic           if_flush_hit_c;

   // Grant: a flushing fetch is never eligible; contention resolved by priority or alternation.
   always_comb begin
      if_eligible_c = i_if_req_valid && !i_if_flush;
      grant_valid_c = 1'b0;
      grant_c       = MEM_OWNER_IF;
      if ((state_q == MEM_ARB_IDLE) && !i_rst) begin
         if (if_eligible_c && i_ls_req_valid) begin
            grant_valid_c = 1'b1;
            grant_c       = (LS_PRIORITY || (last_grant_q == MEM_OWNER_IF)) ? MEM_OWNER_LS
                                                                           : MEM_OWNER_IF;
         end else if (i_ls_req_valid) begin
            grant_valid_c = 1'b1;
            grant_c       = MEM_OWNER_LS;
         end else if (if_eligible_c) begin
            grant_valid_c = 1'b1;
            grant_c       = MEM_OWNER_IF;
         end
      end
   end

   assign o_if_req_ready = grant_valid_c && (grant_c == MEM_OWNER_IF);
   assign o_ls_req_ready = grant_valid_c && (grant_c == MEM_OWNER_LS);
   assign if_flush_hit_c = i_if_flush && (owner_q == MEM_OWNER_IF);

   always_comb begin
      state_d         = state_q;
      owner_d         = owner_q;
      last_grant_d    = last_grant_q;
      drop_d          = drop_q;
      req_d           = req_q;
      mem_req_valid_d = mem_req_valid_q;
      if_rsp_valid_d  = 1'b0;
      if_rsp_data_d   = if_rsp_data_q;
      if_rsp_err_d    = if_rsp_err_q;
      ls_rsp_valid_d  = 1'b0;
      ls_rsp_rdata_d  = ls_rsp_rdata_q;
      ls_rsp_err_d    = ls_rsp_err_q;

      case (state_q)
         MEM_ARB_IDLE: begin
            drop_d = 1'b0;
            if (grant_valid_c) begin
               owner_d         = grant_c;
               last_grant_d    = grant_c;
               mem_req_valid_d = 1'b1;
               state_d         = MEM_ARB_REQ;
               if (grant_c == MEM_OWNER_LS) begin
                  req_d.addr  = i_ls_addr;
                  req_d.wen   = i_ls_wen;
                  req_d.wdata = i_ls_wdata;
                  req_d.wstrb = i_ls_wstrb;
               end else begin
                  req_d.addr  = i_if_addr;
                  req_d.wen   = 1'b0;
                  req_d.wdata = '0;
                  req_d.wstrb = '0;
               end
            end
         end

         MEM_ARB_REQ: begin
            if (if_flush_hit_c) begin
               drop_d = 1'b1;
            end
            if (i_mem_req_ready) begin
               mem_req_valid_d = 1'b0;
               state_d         = MEM_ARB_WAIT_RSP;
            end
         end

         MEM_ARB_WAIT_RSP: begin
            if (i_mem_rsp_valid) begin
               state_d = MEM_ARB_IDLE;
               drop_d  = 1'b0;
               if (owner_q == MEM_OWNER_LS) begin
                  ls_rsp_valid_d = 1'b1;
                  ls_rsp_rdata_d = i_mem_rsp_rdata;
                  ls_rsp_err_d   = i_mem_rsp_err;
               end else if (!(drop_q || i_if_flush)) begin
                  // A flush landing with the response kills it as well.
                  if_rsp_valid_d = 1'b1;
                  if_rsp_data_d  = i_mem_rsp_rdata;
                  if_rsp_err_d   = i_mem_rsp_err;
               end
            end else if (if_flush_hit_c) begin
               drop_d = 1'b1;
            end
         end

         default: begin
            state_d         = MEM_ARB_IDLE;
            mem_req_valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q         <= MEM_ARB_IDLE;
         owner_q         <= MEM_OWNER_IF;
         last_grant_q    <= MEM_OWNER_IF;
         drop_q          <= 1'b0;
         req_q           <= '0;
         mem_req_valid_q <= 1'b0;
         if_rsp_valid_q  <= 1'b0;
         if_rsp_data_q   <= '0;
         if_rsp_err_q    <= 1'b0;
         ls_rsp_valid_q  <= 1'b0;
         ls_rsp_rdata_q  <= '0;
         ls_rsp_err_q    <= 1'b0;
      end else begin
         state_q         <= state_d;
         owner_q         <= owner_d;
         last_grant_q    <= last_grant_d;
         drop_q          <= drop_d;
         req_q           <= req_d;
         mem_req_valid_q <= mem_req_valid_d;
         if_rsp_valid_q  <= if_rsp_valid_d;
         if_rsp_data_q   <= if_rsp_data_d;
         if_rsp_err_q    <= if_rsp_err_d;
         ls_rsp_valid_q  <= ls_rsp_valid_d;
         ls_rsp_rdata_q  <= ls_rsp_rdata_d;
         ls_rsp_err_q    <= ls_rsp_err_d;
      end
   end

   assign o_mem_req_valid = mem_req_valid_q;
   assign o_mem_addr      = req_q.addr;
   assign o_mem_wen       = req_q.wen;
   assign o_mem_wdata     = req_q.wdata;
   assign o_mem_wstrb     = req_q.wstrb;
   assign o_if_rsp_valid  = if_rsp_valid_q;
   assign o_if_rsp_data   = if_rsp_data_q;
   assign o_if_rsp_err    = if_rsp_err_q;
   assign o_ls_rsp_valid  = ls_rsp_valid_q;
   assign o_ls_rsp_rdata  = ls_rsp_rdata_q;
   assign o_ls_rsp_err    = ls_rsp_err_q;

endmodule

// File: tb/tb_core_mem_arbiter.sv
// Bench for core_mem_arbiter: round-robin (dut0) and LS-priority (dut1) instances share stimulus.
module tb_core_mem_arbiter;
   import core_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_valid, if_flush, ls_valid, ls_wen, mem_ready, mem_rsp_valid, mem_err;
   logic [31:0] if_addr, ls_addr, ls_wdata, mem_rdata;
   logic [3:0]  ls_wstrb;

   logic        if_rdy [2];
   logic        ls_rdy [2];
   logic        if_rv  [2];
   logic [31:0] if_rd  [2];
   logic        if_re  [2];
   logic        ls_rv  [2];
   logic [31:0] ls_rd  [2];
   logic        ls_re  [2];
   logic        mv     [2];
   logic [31:0] ma     [2];
   logic        mwen   [2];
   logic [31:0] mwd    [2];
   logic [3:0]  mws    [2];

   always #5 clk = ~clk;

   for (genvar g = 0; g < 2; g++) begin : g_dut
      core_mem_arbiter #(.LS_PRIORITY(g == 1)) u_dut (
         .i_clk           (clk),
         .i_rst           (rst),
         .i_if_req_valid  (if_valid),
         .o_if_req_ready  (if_rdy[g]),
         .i_if_addr       (if_addr),
         .i_if_flush      (if_flush),
         .o_if_rsp_valid  (if_rv[g]),
         .o_if_rsp_data   (if_rd[g]),
         .o_if_rsp_err    (if_re[g]),
         .i_ls_req_valid  (ls_valid),
         .o_ls_req_ready  (ls_rdy[g]),
         .i_ls_addr       (ls_addr),
         .i_ls_wen        (ls_wen),
         .i_ls_wdata      (ls_wdata),
         .i_ls_wstrb      (ls_wstrb),
         .o_ls_rsp_valid  (ls_rv[g]),
         .o_ls_rsp_rdata  (ls_rd[g]),
         .o_ls_rsp_err    (ls_re[g]),
         .o_mem_req_valid (mv[g]),
         .i_mem_req_ready (mem_ready),
         .o_mem_addr      (ma[g]),
         .o_mem_wen       (mwen[g]),
         .o_mem_wdata     (mwd[g]),
         .o_mem_wstrb     (mws[g]),
         .i_mem_rsp_valid (mem_rsp_valid),
         .i_mem_rsp_rdata (mem_rdata),
         .i_mem_rsp_err   (mem_err)
      );
   end

   int checks = 0;
   int errors = 0;

   // Transaction-level model: one outstanding access, its payload, pending pulses.
   bit          m_busy [2], m_pend [2], m_own_ls [2], m_drop [2], m_last_ls [2];
   bit          m_if_pulse [2], m_ls_pulse [2], m_wen [2], m_err [2];
   logic [31:0] m_addr [2], m_wdata [2], m_rdata [2];
   logic [3:0]  m_wstrb [2];
   int          glog0 [$];
   int          glog1 [$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   task automatic model_reset(input int k);
      m_busy[k] = 0; m_pend[k] = 0; m_own_ls[k] = 0; m_drop[k] = 0; m_last_ls[k] = 0;
      m_if_pulse[k] = 0; m_ls_pulse[k] = 0;
   endtask

   task automatic model_step();
      bit    if_ok, win_ls, win_if;
      string p;
      for (int k = 0; k < 2; k++) begin
         p = $sformatf("dut%0d", k);
         if (rst) begin
            chk({p, " rst if_rdy"}, 32'(if_rdy[k]), 32'd0);
            chk({p, " rst ls_rdy"}, 32'(ls_rdy[k]), 32'd0);
            chk({p, " rst mem_valid"}, 32'(mv[k]), 32'd0);
            chk({p, " rst mem_addr"}, ma[k], 32'd0);
            chk({p, " rst if_rsp_valid"}, 32'(if_rv[k]), 32'd0);
            chk({p, " rst ls_rsp_valid"}, 32'(ls_rv[k]), 32'd0);
            model_reset(k);
            continue;
         end
         if_ok  = if_valid && !if_flush;
         win_ls = !m_busy[k] && ls_valid && (!if_ok || (k == 1) || !m_last_ls[k]);
         win_if = !m_busy[k] && if_ok && !win_ls;
         chk({p, " if_req_ready"}, 32'(if_rdy[k]), 32'(win_if));
         chk({p, " ls_req_ready"}, 32'(ls_rdy[k]), 32'(win_ls));
         if (ls_rdy[k] || if_rdy[k]) begin
            if (k == 0) glog0.push_back(ls_rdy[k] ? 1 : 0);
            else        glog1.push_back(ls_rdy[k] ? 1 : 0);
         end
         chk({p, " mem_req_valid"}, 32'(mv[k]), 32'(m_pend[k]));
         if (m_pend[k]) begin
            chk({p, " mem_addr"}, ma[k], m_addr[k]);
            chk({p, " mem_wen"}, 32'(mwen[k]), 32'(m_wen[k]));
            chk({p, " mem_wdata"}, mwd[k], m_wdata[k]);
            chk({p, " mem_wstrb"}, 32'(mws[k]), 32'(m_wstrb[k]));
         end
         chk({p, " if_rsp_valid"}, 32'(if_rv[k]), 32'(m_if_pulse[k]));
         chk({p, " ls_rsp_valid"}, 32'(ls_rv[k]), 32'(m_ls_pulse[k]));
         if (m_if_pulse[k]) begin
            chk({p, " if_rsp_data"}, if_rd[k], m_rdata[k]);
            chk({p, " if_rsp_err"}, 32'(if_re[k]), 32'(m_err[k]));
         end
         if (m_ls_pulse[k]) begin
            chk({p, " ls_rsp_rdata"}, ls_rd[k], m_rdata[k]);
            chk({p, " ls_rsp_err"}, 32'(ls_re[k]), 32'(m_err[k]));
         end
         // Advance to what the coming clock edge must produce.
         m_if_pulse[k] = 0;
         m_ls_pulse[k] = 0;
         if (!m_busy[k]) begin
            if (win_ls || win_if) begin
               m_busy[k] = 1; m_pend[k] = 1; m_drop[k] = 0;
               m_own_ls[k] = win_ls; m_last_ls[k] = win_ls;
               m_addr[k]  = win_ls ? ls_addr : if_addr;
               m_wen[k]   = win_ls && ls_wen;
               m_wdata[k] = win_ls ? ls_wdata : 32'd0;
               m_wstrb[k] = win_ls ? ls_wstrb : 4'd0;
            end
         end else if (m_pend[k]) begin
            if (if_flush && !m_own_ls[k]) m_drop[k] = 1;
            if (mem_ready) m_pend[k] = 0;
         end else if (mem_rsp_valid) begin
            m_busy[k] = 0;
            if (m_own_ls[k]) m_ls_pulse[k] = 1;
            else if (!(m_drop[k] || if_flush)) m_if_pulse[k] = 1;
            m_rdata[k] = mem_rdata;
            m_err[k]   = mem_err;
         end else if (if_flush && !m_own_ls[k]) begin
            m_drop[k] = 1;
         end
      end
   endtask

   task automatic tick();
      @(negedge clk);
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      if_valid = 0; if_flush = 0; if_addr = '0;
      ls_valid = 0; ls_wen = 0; ls_addr = '0; ls_wdata = '0; ls_wstrb = '0;
      mem_ready = 0; mem_rsp_valid = 0; mem_rdata = '0; mem_err = 0;
   endtask

   int n_if0;

   initial begin
      for (int k = 0; k < 2; k++) model_reset(k);
      rst = 1;
      clear_inputs();
      tick();
      tick();
      rst = 0;

      // Single fetch, minimum latency.
      if_valid = 1; if_addr = 32'h0000_1000; mem_ready = 1;
      tick();
      if_valid = 0;
      chk("s1 mem_valid", 32'(mv[0]), 32'd1);
      chk("s1 mem_addr", ma[0], 32'h0000_1000);
      chk("s1 mem_wen", 32'(mwen[0]), 32'd0);
      tick();
      mem_rsp_valid = 1; mem_rdata = 32'h0000_0013;
      tick();
      mem_rsp_valid = 0;
      chk("s1 if_rsp_valid", 32'(if_rv[0]), 32'd1);
      chk("s1 if_rsp_data", if_rd[0], 32'h0000_0013);
      chk("s1 ls_rsp_valid", 32'(ls_rv[0]), 32'd0);
      tick();
      tick();

      // Contention from reset, memory always ready and answering.
      rst = 1;
      tick();
      rst = 0;
      glog0.delete();
      glog1.delete();
      if_valid = 1; if_addr = 32'h100; ls_valid = 1; ls_addr = 32'h200;
      mem_ready = 1; mem_rsp_valid = 1;
      for (int i = 0; i < 16; i++) begin
         mem_rdata = 32'(i) + 32'h50;
         tick();
      end
      chk("s2 dut0 grant count", 32'(glog0.size()), 32'd6);
      chk("s2 dut1 grant count", 32'(glog1.size()), 32'd6);
      if (glog0.size() >= 4) begin
         chk("s2 dut0 grant0 LS", 32'(glog0[0]), 32'd1);
         chk("s2 dut0 grant1 IF", 32'(glog0[1]), 32'd0);
         chk("s2 dut0 grant2 LS", 32'(glog0[2]), 32'd1);
         chk("s2 dut0 grant3 IF", 32'(glog0[3]), 32'd0);
      end
      n_if0 = 0;
      foreach (glog1[i]) if (glog1[i] == 0) n_if0++;
      chk("s2 dut1 IF grants under contention", 32'(n_if0), 32'd0);
      ls_valid = 0;
      for (int i = 0; i < 4; i++) tick();
      chk("s2 dut1 grant count after LS idle", 32'(glog1.size()), 32'd7);
      if (glog1.size() == 7) chk("s2 dut1 IF granted alone", 32'(glog1[6]), 32'd0);
      if_valid = 0;
      for (int i = 0; i < 4; i++) tick();
      clear_inputs();
      tick();

      // Store stalled downstream for five cycles.
      ls_valid = 1; ls_addr = 32'h0000_2004; ls_wen = 1; ls_wdata = 32'hDEAD_BEEF; ls_wstrb = 4'b0011;
      tick();
      for (int i = 1; i <= 5; i++) begin
         chk($sformatf("s3 c%0d mem_valid", i), 32'(mv[0]), 32'd1);
         chk($sformatf("s3 c%0d mem_addr", i), ma[0], 32'h0000_2004);
         chk($sformatf("s3 c%0d mem_wen", i), 32'(mwen[0]), 32'd1);
         chk($sformatf("s3 c%0d mem_wdata", i), mwd[0], 32'hDEAD_BEEF);
         chk($sformatf("s3 c%0d mem_wstrb", i), 32'(mws[0]), 32'h3);
         chk($sformatf("s3 c%0d ls_ready", i), 32'(ls_rdy[0]), 32'd0);
         tick();
      end
      mem_ready = 1; ls_valid = 0;
      tick();
      mem_ready = 0; mem_rsp_valid = 1; mem_rdata = 32'h0000_1234; mem_err = 1;
      tick();
      clear_inputs();
      chk("s3 ls_rsp_valid", 32'(ls_rv[0]), 32'd1);
      chk("s3 ls_rsp_err", 32'(ls_re[0]), 32'd1);
      chk("s3 if_rsp_valid", 32'(if_rv[0]), 32'd0);
      tick();

      // Flush during WAIT_RSP drops the fetch response.
      if_valid = 1; if_addr = 32'h0000_3000; mem_ready = 1;
      tick();
      if_valid = 0;
      tick();
      if_flush = 1;
      tick();
      if_flush = 0; mem_rsp_valid = 1; mem_rdata = 32'hAAAA_AAAA;
      tick();
      mem_rsp_valid = 0;
      chk("s4 dropped rsp", 32'(if_rv[0]), 32'd0);
      tick();
      chk("s4 dropped rsp late", 32'(if_rv[0]), 32'd0);
      if_valid = 1; if_addr = 32'h0000_3004;
      tick();
      if_valid = 0;
      tick();
      mem_rsp_valid = 1; mem_rdata = 32'h0000_0055;
      tick();
      mem_rsp_valid = 0;
      chk("s4 next fetch rsp_valid", 32'(if_rv[0]), 32'd1);
      chk("s4 next fetch rsp_data", if_rd[0], 32'h0000_0055);
      // Flush coincident with the response.
      if_valid = 1; if_addr = 32'h0000_3008;
      tick();
      if_valid = 0;
      tick();
      if_flush = 1; mem_rsp_valid = 1; mem_rdata = 32'h0000_00BB;
      tick();
      if_flush = 0; mem_rsp_valid = 0;
      chk("s4 coincident flush drop", 32'(if_rv[0]), 32'd0);
      // Flush blocks an IF grant in IDLE.
      if_valid = 1; if_flush = 1;
      #1;
      chk("s4 flush blocks grant", 32'(if_rdy[0]), 32'd0);
      tick();
      if_valid = 0; if_flush = 0;
      // Flush has no effect on an LS transaction.
      ls_valid = 1; ls_addr = 32'h0000_0040;
      tick();
      ls_valid = 0;
      tick();
      if_flush = 1; mem_rsp_valid = 1; mem_rdata = 32'h0000_0077;
      tick();
      if_flush = 0; mem_rsp_valid = 0;
      chk("s4 ls rsp despite flush", 32'(ls_rv[0]), 32'd1);
      chk("s4 ls rsp data", ls_rd[0], 32'h0000_0077);
      tick();

      // Reset while waiting for a response, then a stray response.
      if_valid = 1; if_addr = 32'h0000_5000;
      tick();
      if_valid = 0;
      tick();
      #2;
      rst = 1;
      #1;
      chk("s5 async mem_addr", ma[0], 32'd0);
      chk("s5 async mem_valid", 32'(mv[0]), 32'd0);
      chk("s5 async if_ready", 32'(if_rdy[0]), 32'd0);
      tick();
      rst = 0;
      mem_rsp_valid = 1; mem_rdata = 32'h0000_00EE;
      tick();
      mem_rsp_valid = 0;
      chk("s5 stray rsp ignored", 32'(if_rv[0]), 32'd0);
      if_valid = 1; if_addr = 32'h0000_6000;
      tick();
      if_valid = 0;
      chk("s5 post-reset grant mem_valid", 32'(mv[0]), 32'd1);
      chk("s5 post-reset grant mem_addr", ma[0], 32'h0000_6000);
      tick();
      mem_rsp_valid = 1; mem_rdata = 32'h0000_0066;
      tick();
      mem_rsp_valid = 0;
      chk("s5 post-reset rsp", 32'(if_rv[0]), 32'd1);
      tick();
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
